// File: rtl/ofmap_serializer.sv
// Serializes packed NUM_INPUTS-lane activation vectors into a single-lane
// valid/ready stream, lane 0 first, honouring a per-vector valid-lane count.
module ofmap_serializer #(
    parameter int unsigned  DATA_WIDTH = 16,
    parameter int unsigned  NUM_INPUTS = 4,
    localparam int unsigned LW         = $clog2(NUM_INPUTS + 1)
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_INPUTS*DATA_WIDTH-1:0] in_data,
    input  logic [LW-1:0]                    in_lanes,
    input  logic                             in_valid,
    output logic                             in_ready,
    output logic [DATA_WIDTH-1:0]            out_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic                             out_last,
    output logic                             busy
);

    localparam int unsigned IW = $clog2(NUM_INPUTS);
    localparam int unsigned VW = NUM_INPUTS * DATA_WIDTH;

    typedef enum logic {
        S_IDLE,
        S_SEND
    } state_t;

    state_t                  r_state;
    logic [VW-1:0]           r_buf;
    logic [IW-1:0]           r_idx;
    logic [IW-1:0]           r_last_idx;
    logic [DATA_WIDTH-1:0]   r_out_data;
    logic                    r_out_valid;
    logic                    r_out_last;
    logic                    r_busy;

    logic [LW-1:0]           w_n_eff;
    logic [IW-1:0]           w_last_idx;
    logic [IW-1:0]           w_idx_next;
    logic                    w_accept;

    // Zero or oversized lane counts mean a full vector.
    assign w_n_eff    = (in_lanes == '0 || in_lanes > LW'(NUM_INPUTS)) ? LW'(NUM_INPUTS) : in_lanes;
    assign w_last_idx = IW'(w_n_eff - LW'(1));
    assign w_idx_next = r_idx + IW'(1);

    // Accepting on the final beat keeps back-to-back vectors bubble-free.
    assign in_ready = !reset && ((r_state == S_IDLE) ||
                                 (r_state == S_SEND && r_out_last && out_ready));
    assign w_accept = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_buf       <= '0;
            r_idx       <= '0;
            r_last_idx  <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_busy      <= 1'b0;
        end else if (w_accept) begin
            r_state     <= S_SEND;
            r_buf       <= in_data;
            r_idx       <= '0;
            r_last_idx  <= w_last_idx;
            r_out_data  <= in_data[DATA_WIDTH-1:0];
            r_out_valid <= 1'b1;
            r_out_last  <= (w_last_idx == '0);
            r_busy      <= 1'b1;
        end else if (r_state == S_SEND && out_ready) begin
            if (r_out_last) begin
                r_state     <= S_IDLE;
                r_out_valid <= 1'b0;
                r_out_last  <= 1'b0;
                r_busy      <= 1'b0;
            end else begin
                // Buffer shifts down so the current lane always sits at the bottom.
                r_buf       <= r_buf >> DATA_WIDTH;
                r_idx       <= w_idx_next;
                r_out_data  <= r_buf[2*DATA_WIDTH-1:DATA_WIDTH];
                r_out_last  <= (w_idx_next == r_last_idx);
            end
        end
    end

    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign out_last  = r_out_last;
    assign busy      = r_busy;

endmodule

// File: tb/tb_ofmap_serializer.sv
// Scoreboard bench for ofmap_serializer: accepted vectors are expanded into
// expected beats, and a negedge monitor checks every cycle of the stream.
module tb_ofmap_serializer;

    localparam int unsigned DW = 16;
    localparam int unsigned NI = 4;
    localparam int unsigned LW = $clog2(NI + 1);

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    logic               clk = 1'b0;
    logic               reset;
    logic [NI*DW-1:0]   in_data;
    logic [LW-1:0]      in_lanes;
    logic               in_valid;
    logic               in_ready;
    logic [DW-1:0]      out_data;
    logic               out_valid;
    logic               out_ready;
    logic               out_last;
    logic               busy;

    beat_t         q[$];
    logic [DW-1:0] hold_data;
    logic          acc;
    int            checks;
    int            errors;
    int            cycles;
    int            rdy_mode;
    int            pat_idx;
    logic [6:0]    pat;

    ofmap_serializer #(.DATA_WIDTH(DW), .NUM_INPUTS(NI)) dut (
        .clk(clk), .reset(reset),
        .in_data(in_data), .in_lanes(in_lanes), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Reference: a vector is just its first n lanes in ascending order.
    task automatic push_vector(input logic [NI*DW-1:0] d, input logic [LW-1:0] lanes);
        int n;
        beat_t b;
        n = (lanes == 0 || int'(lanes) > NI) ? NI : int'(lanes);
        for (int i = 0; i < n; i++) begin
            b.data = d[i*DW +: DW];
            b.last = (i == n - 1);
            q.push_back(b);
        end
    endtask

    // Monitor: compare outputs against the scoreboard head every cycle.
    always @(negedge clk) begin
        cycles++;
        if (cycles > 50000) begin
            $display("FAIL watchdog: got %0d cycles expected fewer than 50000", cycles);
            $fatal(1, "watchdog");
        end
        if (reset) begin
            chk("in_ready_in_reset", 32'(in_ready), 32'd0);
            q.delete();
            hold_data = '0;
            acc = 1'b0;
        end else begin
            chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
            chk("busy", 32'(busy), 32'(q.size() > 0));
            chk("in_ready", 32'(in_ready),
                32'(q.size() == 0 || (q.size() == 1 && out_ready)));
            if (out_valid && q.size() > 0) begin
                chk("out_data", 32'(out_data), 32'(q[0].data));
                chk("out_last", 32'(out_last), 32'(q[0].last));
            end else if (!out_valid) begin
                chk("idle_out_data", 32'(out_data), 32'(hold_data));
            end
            if (out_valid && out_ready && q.size() > 0) begin
                hold_data = q[0].data;
                void'(q.pop_front());
            end
            acc = in_valid && in_ready;
            if (acc) push_vector(in_data, in_lanes);
        end
    end

    // out_ready driver: 0 = always ready, 1 = random, 2 = fixed stall pattern.
    always @(posedge clk) begin
        #2;
        case (rdy_mode)
            1: out_ready = 1'($urandom_range(0, 1));
            2: begin
                out_ready = (pat_idx < 7) ? pat[6 - pat_idx] : 1'b1;
                pat_idx++;
            end
            default: out_ready = 1'b1;
        endcase
    end

    // Called at posedge+1; returns at posedge+1 right after the accepting edge.
    task automatic send_vec(input logic [NI*DW-1:0] d, input logic [LW-1:0] lanes);
        int t;
        in_valid = 1'b1;
        in_data  = d;
        in_lanes = lanes;
        t = 0;
        while (1) begin
            @(posedge clk);
            #1;
            if (acc) break;
            t++;
            if (t > 200) begin
                errors++;
                $display("FAIL accept_timeout: got no accept expected accept within 200 cycles");
                break;
            end
        end
        in_valid = 1'b0;
        in_data  = {$urandom, $urandom};
        in_lanes = LW'($urandom_range(0, 7));
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (q.size() > 0 && t < 1000) begin
            @(posedge clk);
            t++;
        end
        #1;
        if (t >= 1000) begin
            errors++;
            $display("FAIL drain_timeout: got %0d beats pending expected 0", q.size());
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        cycles    = 0;
        rdy_mode  = 0;
        pat_idx   = 0;
        pat       = 7'b1001101;
        hold_data = '0;
        acc       = 1'b0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_lanes  = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1;

        send_vec({16'h0004, 16'h0003, 16'h0002, 16'h0001}, 3'd4);
        drain();

        send_vec({16'h0004, 16'h0003, 16'h0002, 16'h0001}, 3'd4);
        send_vec({16'h0008, 16'h0007, 16'h0006, 16'h0005}, 3'd4);
        drain();

        send_vec({16'hDEAD, 16'hBEEF, 16'h0B0B, 16'h0A0A}, 3'd2);
        drain();
        send_vec({16'hDEAD, 16'hBEEF, 16'h0B0B, 16'h0A0A}, 3'd0);
        drain();
        send_vec({16'hDEAD, 16'hBEEF, 16'h0B0B, 16'h0A0A}, 3'd7);
        drain();
        send_vec({16'hDEAD, 16'hBEEF, 16'h0B0B, 16'h0A0A}, 3'd1);
        drain();

        pat_idx  = 0;
        rdy_mode = 2;
        send_vec({16'h0004, 16'h0003, 16'h0002, 16'h0001}, 3'd4);
        drain();
        rdy_mode = 0;

        // Reset while lane 2 is presented, then a fresh vector from lane 0.
        send_vec({16'h0004, 16'h0003, 16'h0002, 16'h0001}, 3'd4);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1;
        send_vec({16'h000C, 16'h000B, 16'h000A, 16'h0009}, 3'd4);
        drain();

        rdy_mode = 1;
        for (int v = 0; v < 300; v++) begin
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
            send_vec({$urandom, $urandom}, LW'($urandom_range(0, 7)));
        end
        drain();
        rdy_mode = 0;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
